sample_collector: RTL

Command-side reader for the per-pin sample return bus. It scans the pin controllers round-robin with `output_sample`/`channel_select` and reads the OR-combined `sample_data` bus. Each new sample it finds is pushed into an internal FIFO, which the host interface drains. It sits between the pin controller array and the USB/EBI read path.

---
 rtl/sample_collector_pkg.sv | 32 +++
 rtl/sample_collector_if.sv | 38 +++
 rtl/sample_fifo.sv | 55 +++++
 rtl/sample_collector.sv | 99 +++++++++
 4 files changed

// File: rtl/sample_collector_pkg.sv
// Shared definitions for sample_collector: sample word field bounds, FSM encoding
// and FIFO entry width (64 bits when SAMPLE_COLLECTOR_TIMESTAMP_EN is defined).
package sample_collector_pkg;

  localparam int CNT_MSB = 31;
  localparam int CNT_LSB = 16;
  localparam int POS_MSB = 15;
  localparam int POS_LSB = 1;
  localparam int VAL_BIT = 0;

  localparam logic [3:0] ST_IDLE    = 4'b0001;
  localparam logic [3:0] ST_ISSUE   = 4'b0010;
  localparam logic [3:0] ST_WAIT    = 4'b0100;
  localparam logic [3:0] ST_CAPTURE = 4'b1000;

`ifdef SAMPLE_COLLECTOR_TIMESTAMP_EN
  localparam int ENTRY_W = 64;
`else
  localparam int ENTRY_W = 32;
`endif

  typedef logic [ENTRY_W-1:0] entry_t;

  function automatic logic [CNT_MSB-CNT_LSB:0] sampleCnt(input logic [31:0] word);
    return word[CNT_MSB:CNT_LSB];
  endfunction

  function automatic logic [POS_MSB-POS_LSB:0] samplePos(input logic [31:0] word);
    return word[POS_MSB:POS_LSB];
  endfunction

endpackage

// File: rtl/sample_collector_if.sv
// Signal bundle between sample_collector (master) and the pin array / host (slave).
// SAMPLE_COLLECTOR_TIMESTAMP_EN adds current_time and widens fifo_dout.
interface sample_collector_if #(
  parameter int FIFO_DEPTH = 32
);
  import sample_collector_pkg::*;

  logic                        enable;
  logic                        output_sample;
  logic [7:0]                  channel_select;
  logic [31:0]                 sample_data;
  logic                        fifo_rd;
  entry_t                      fifo_dout;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        overflow;
  logic                        clear_overflow;
`ifdef SAMPLE_COLLECTOR_TIMESTAMP_EN
  logic [31:0]                 current_time;
`endif

  modport master (
    input  enable, sample_data, fifo_rd, clear_overflow,
`ifdef SAMPLE_COLLECTOR_TIMESTAMP_EN
    input  current_time,
`endif
    output output_sample, channel_select, fifo_dout, fifo_empty, fifo_count, overflow
  );

  modport slave (
    output enable, sample_data, fifo_rd, clear_overflow,
`ifdef SAMPLE_COLLECTOR_TIMESTAMP_EN
    output current_time,
`endif
    input  output_sample, channel_select, fifo_dout, fifo_empty, fifo_count, overflow
  );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO with active-low async reset.
// A write and a read in the same cycle both succeed, even when full.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doRead;
  logic             doWrite;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign doRead    = rd_en_i && !empty_o;
  assign doWrite   = wr_en_i && (!full_o || doRead);
  assign count_o   = count_q;
  // Empty reads as zero so the head is defined straight out of reset.
  assign rd_data_o = empty_o ? '0 : mem_q[rdPtr_q];

  always_ff @(posedge clk) begin
    if (doWrite) mem_q[wrPtr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doWrite) wrPtr_q <= wrPtr_q + 1'b1;
      if (doRead)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doWrite, doRead})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sample_collector.sv
// Round-robin scanner of the pin sample return bus; new samples go into a FWFT FIFO.
// Reset is active-low. SAMPLE_COLLECTOR_TIMESTAMP_EN prepends current_time to entries.
module sample_collector
  import sample_collector_pkg::*;
#(
  parameter int NUM_CHANNELS = 16,
  parameter int FIFO_DEPTH   = 32
) (
  input logic                clk,
  input logic                reset,
  sample_collector_if.master bus
);
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  logic [3:0]      state_q, state_d;
  logic [CH_W-1:0] chan_q, chan_d;
  logic            strobe_q;
  logic [7:0]      chanSel_q;
  logic [15:0]     lastCnt_q [2**CH_W];
  logic            overflow_q;
  logic            isNew;
  logic            pushReq;
  logic            fifoFull;
  logic            dropWord;
  entry_t          entry;

  assign isNew = (samplePos(bus.sample_data) == 15'(chan_q)) &&
                 (sampleCnt(bus.sample_data) != lastCnt_q[chan_q]);
  assign pushReq = (state_q == ST_CAPTURE) && isNew;
  // A full FIFO is never empty, so a concurrent fifo_rd always frees a slot.
  assign dropWord = pushReq && fifoFull && !bus.fifo_rd;

`ifdef SAMPLE_COLLECTOR_TIMESTAMP_EN
  assign entry = {bus.current_time, bus.sample_data};
`else
  assign entry = bus.sample_data;
`endif

  assign bus.output_sample  = strobe_q;
  assign bus.channel_select = chanSel_q;
  assign bus.overflow       = overflow_q;

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          state_d = ST_ISSUE;
          chan_d  = '0;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        chan_d  = (chan_q == LAST_CH) ? '0 : chan_q + 1'b1;
        state_d = bus.enable ? ST_ISSUE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe and channel are registered from the next state so they are high for ISSUE only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      chan_q     <= '0;
      strobe_q   <= 1'b0;
      chanSel_q  <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < 2**CH_W; i++) lastCnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      strobe_q <= (state_d == ST_ISSUE);
      if (state_d == ST_ISSUE) chanSel_q <= 8'(chan_d);
      if (pushReq) lastCnt_q[chan_q] <= sampleCnt(bus.sample_data);
      if (dropWord) overflow_q <= 1'b1;
      else if (bus.clear_overflow) overflow_q <= 1'b0;
    end
  end

  sample_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (pushReq),
    .wr_data_i (entry),
    .rd_en_i   (bus.fifo_rd),
    .rd_data_o (bus.fifo_dout),
    .count_o   (bus.fifo_count),
    .empty_o   (bus.fifo_empty),
    .full_o    (fifoFull)
  );

endmodule
